// File: rtl/proc_integration4_datapath_pkg.sv
// proc_integration4_datapath_pkg: shared widths, constants and select encodings for the datapath slice
package proc_integration4_datapath_pkg;
    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] CONST4 = 16'h0004;
    typedef enum logic [2:0] {
        DD_ALUOUT, DD_IRSHIFT, DD_B, DD_A, DD_M, DD_CONST4, DD_ZERO6, DD_ZERO7
    } dest_data_e;
    typedef enum logic [2:0] {
        ALU_AND, ALU_ADD, ALU_SUB, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;
endpackage

// File: rtl/proc_integration4_datapath_alu.sv
// datapath_alu: 16-bit combinational ALU with signed overflow for ADD/SUB
module datapath_alu
    import proc_integration4_datapath_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);
    always_comb begin
        result = '0;
        case (alu_op_e'(op))
            ALU_AND: result = a & b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << b[3:0];
            ALU_SRL: result = a >> b[3:0];
            ALU_SRA: result = $unsigned($signed(a) >>> b[3:0]);
            default: result = '0;
        endcase
    end
    // Overflow when operand signs make the result sign impossible
    assign overflow = (alu_op_e'(op) == ALU_ADD) ? (a[15] == b[15]) && (result[15] != a[15]) :
                      (alu_op_e'(op) == ALU_SUB) ? (a[15] != b[15]) && (result[15] != a[15]) : 1'b0;
endmodule

// File: rtl/proc_integration4_datapath.sv
// proc_integration4_datapath: IR, immediate, accumulator file, A/B/M/ALUOut registers and zero flag
module proc_integration4_datapath
    import proc_integration4_datapath_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [DATA_W-1:0] Data_In,
    input  logic              IR_Write,
    input  logic              ItypeSel,
    input  logic              Asel,
    input  logic              Awrite,
    input  logic              Bsel,
    input  logic              Bwrite,
    input  logic [2:0]        ALUcontrol,
    input  logic              ALUOutWrite,
    input  logic              iszero_write,
    input  logic [DATA_W-1:0] M_Data_In,
    input  logic              Mwrite,
    input  logic [2:0]        destData,
    input  logic [1:0]        destAddr,
    input  logic              reg_write,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] ALU_output,
    output logic              overflow_out,
    output logic              isZero,
    output logic [DATA_W-1:0] ALUOut_output,
    output logic [DATA_W-1:0] Acc_Out,
    output logic [DATA_W-1:0] write_Data
);
    logic [DATA_W-1:0] acc [4];
    logic [DATA_W-1:0] m_reg;
    logic [DATA_W-1:0] imm;

    assign imm     = ItypeSel ? {8'h00, IR[7:0]} : {{8{IR[7]}}, IR[7:0]};
    assign Acc_Out = acc[destAddr];

    always_comb begin
        write_Data = '0;
        case (dest_data_e'(destData))
            DD_ALUOUT:  write_Data = ALUOut_output;
            DD_IRSHIFT: write_Data = {IR[11:0], 4'h0};
            DD_B:       write_Data = B;
            DD_A:       write_Data = A;
            DD_M:       write_Data = m_reg;
            DD_CONST4:  write_Data = CONST4;
            default:    write_Data = '0;
        endcase
    end

    datapath_alu u_alu (
        .a        (A),
        .b        (B),
        .op       (ALUcontrol),
        .result   (ALU_output),
        .overflow (overflow_out)
    );

    // Every load samples pre-edge values, so simultaneous strobes never see each other
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            IR            <= '0;
            A             <= '0;
            B             <= '0;
            m_reg         <= '0;
            ALUOut_output <= '0;
            isZero        <= 1'b0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
        end else begin
            if (IR_Write)     IR            <= Data_In;
            if (Awrite)       A             <= Asel ? Acc_Out : m_reg;
            if (Bwrite)       B             <= Bsel ? imm : Acc_Out;
            if (Mwrite)       m_reg         <= M_Data_In;
            if (ALUOutWrite)  ALUOut_output <= ALU_output;
            if (iszero_write) isZero        <= (ALU_output == '0);
            if (reg_write)    acc[destAddr] <= write_Data;
        end
    end
endmodule

// File: tb/tb_proc_integration4_datapath.sv
// tb_proc_integration4_datapath: directed vectors with a queued scoreboard and decoupled monitor
module tb_proc_integration4_datapath;
    logic        Clock = 0;
    logic        Reset_n;
    logic [15:0] Data_In, M_Data_In;
    logic        IR_Write, ItypeSel, Asel, Awrite, Bsel, Bwrite;
    logic [2:0]  ALUcontrol, destData;
    logic        ALUOutWrite, iszero_write, Mwrite, reg_write;
    logic [1:0]  destAddr;
    logic [15:0] IR, A, B, ALU_output, ALUOut_output, Acc_Out, write_Data;
    logic        overflow_out, isZero;

    proc_integration4_datapath dut (
        .Clock(Clock), .Reset_n(Reset_n), .Data_In(Data_In), .IR_Write(IR_Write),
        .ItypeSel(ItypeSel), .Asel(Asel), .Awrite(Awrite), .Bsel(Bsel), .Bwrite(Bwrite),
        .ALUcontrol(ALUcontrol), .ALUOutWrite(ALUOutWrite), .iszero_write(iszero_write),
        .M_Data_In(M_Data_In), .Mwrite(Mwrite), .destData(destData), .destAddr(destAddr),
        .reg_write(reg_write), .IR(IR), .A(A), .B(B), .ALU_output(ALU_output),
        .overflow_out(overflow_out), .isZero(isZero), .ALUOut_output(ALUOut_output),
        .Acc_Out(Acc_Out), .write_Data(write_Data)
    );

    always #5 Clock = ~Clock;

    localparam int S_IR = 0, S_A = 1, S_B = 2, S_ALU = 3, S_OVF = 4, S_ZERO = 5,
                   S_ALUOUT = 6, S_ACC = 7, S_WD = 8;

    typedef struct { int sel; logic [15:0] exp; } item_t;
    item_t sb[$];
    logic  chk_valid = 0;
    int    vectors = 0, miscompares = 0;

    function automatic logic [15:0] observe(int sel);
        case (sel)
            S_IR:     return IR;
            S_A:      return A;
            S_B:      return B;
            S_ALU:    return ALU_output;
            S_OVF:    return {15'd0, overflow_out};
            S_ZERO:   return {15'd0, isZero};
            S_ALUOUT: return ALUOut_output;
            S_ACC:    return Acc_Out;
            default:  return write_Data;
        endcase
    endfunction

    function automatic string sel_name(int sel);
        case (sel)
            S_IR:     return "IR";
            S_A:      return "A";
            S_B:      return "B";
            S_ALU:    return "ALU_output";
            S_OVF:    return "overflow_out";
            S_ZERO:   return "isZero";
            S_ALUOUT: return "ALUOut_output";
            S_ACC:    return "Acc_Out";
            default:  return "write_Data";
        endcase
    endfunction

    // Monitor: pops one expectation per presented check, sampled on the falling edge
    always @(negedge Clock) begin
        if (chk_valid && sb.size() > 0) begin
            item_t it;
            logic [15:0] got;
            it  = sb.pop_front();
            got = observe(it.sel);
            vectors++;
            if (got !== it.exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h at %0t", sel_name(it.sel), got, it.exp, $time);
            end
        end
    end

    task automatic clear_strobes();
        IR_Write = 0; Awrite = 0; Bwrite = 0; ALUOutWrite = 0;
        iszero_write = 0; Mwrite = 0; reg_write = 0;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        clear_strobes();
    endtask

    task automatic check(int sel, logic [15:0] exp);
        sb.push_back('{sel, exp});
        chk_valid = 1;
        @(negedge Clock);
        #1;
        chk_valid = 0;
    endtask

    initial begin
        logic [15:0] sweep [6];
        sweep = '{16'h0009, 16'h8000, 16'h0005, 16'h0004, 16'h0006, 16'h0004};
        Reset_n = 0; Data_In = 0; M_Data_In = 0; ItypeSel = 0; Asel = 0; Bsel = 0;
        ALUcontrol = 0; destData = 0; destAddr = 0;
        clear_strobes();
        step(); step();
        check(S_IR, 0); check(S_A, 0); check(S_B, 0); check(S_ALUOUT, 0); check(S_ZERO, 0);
        for (int i = 0; i < 4; i++) begin
            destAddr = 2'(i);
            check(S_ACC, 0);
        end
        destData = 4; check(S_WD, 0);

        Reset_n = 1;
        Data_In = 16'h0004; IR_Write = 1; step(); check(S_IR, 16'h0004);
        Bsel = 1; Bwrite = 1; step(); check(S_B, 16'h0004);
        destData = 2; destAddr = 1; reg_write = 1; step(); check(S_ACC, 16'h0004);
        Asel = 1; Awrite = 1; step(); check(S_A, 16'h0004);
        Data_In = 16'h0005; IR_Write = 1; step();
        Bsel = 1; Bwrite = 1; step(); check(S_B, 16'h0005);
        ALUcontrol = 1; check(S_ALU, 16'h0009); check(S_OVF, 0);
        ALUOutWrite = 1; step(); check(S_ALUOUT, 16'h0009);

        // IR load with B load at the same edge: B takes the old immediate
        Data_In = 16'h0800; IR_Write = 1; Bsel = 1; Bwrite = 1;
        M_Data_In = 16'h0006; Mwrite = 1; step();
        check(S_IR, 16'h0800); check(S_B, 16'h0005);

        destAddr = 1;
        for (int i = 0; i < 6; i++) begin
            destData = 3'(i); reg_write = 1; step();
            check(S_ACC, sweep[i]);
        end
        destData = 6; check(S_WD, 0);
        destData = 7; check(S_WD, 0);

        // reg_write with Awrite: A takes the old accumulator value
        destData = 1; reg_write = 1; Asel = 1; Awrite = 1; step();
        check(S_A, 16'h0004); check(S_ACC, 16'h8000);
        // ALUOutWrite with Awrite: ALUOut uses old A (4+5)
        ALUcontrol = 1; Asel = 1; Awrite = 1; ALUOutWrite = 1; step();
        check(S_A, 16'h8000); check(S_ALUOUT, 16'h0009);

        destAddr = 0; destData = 3; reg_write = 1; step();
        Bsel = 0; Bwrite = 1; step(); check(S_B, 16'h8000);

        M_Data_In = 16'h7FFF; Mwrite = 1; step();
        Asel = 0; Awrite = 1; step(); check(S_A, 16'h7FFF);
        Data_In = 16'h0001; IR_Write = 1; step();
        ItypeSel = 0; Bsel = 1; Bwrite = 1; step(); check(S_B, 16'h0001);
        ALUcontrol = 1; check(S_ALU, 16'h8000); check(S_OVF, 1);
        ALUcontrol = 2; check(S_ALU, 16'h7FFE); check(S_OVF, 0);
        iszero_write = 1; step(); check(S_ZERO, 0);
        ALUcontrol = 0; check(S_ALU, 16'h0001);
        ALUcontrol = 3; check(S_ALU, 16'h7FFF);
        ALUcontrol = 4; check(S_ALU, 16'h7FFE); check(S_OVF, 0);
        ALUcontrol = 5; check(S_ALU, 16'hFFFE);
        ALUcontrol = 6; check(S_ALU, 16'h3FFF);
        ALUcontrol = 7; check(S_ALU, 16'h3FFF);

        destAddr = 2; destData = 3; reg_write = 1; step();
        Bsel = 0; Bwrite = 1; step(); check(S_B, 16'h7FFF);
        ALUcontrol = 2; check(S_ALU, 0); check(S_OVF, 0);
        iszero_write = 1; step(); check(S_ZERO, 1);

        destAddr = 0; Asel = 1; Awrite = 1; step(); check(S_A, 16'h8000);
        Bsel = 1; Bwrite = 1; step(); check(S_B, 16'h0001);
        ALUcontrol = 2; check(S_ALU, 16'h7FFF); check(S_OVF, 1);
        ALUcontrol = 7; check(S_ALU, 16'hC000);
        ALUcontrol = 6; check(S_ALU, 16'h4000);

        Data_In = 16'h00F0; IR_Write = 1; step();
        ItypeSel = 0; Bsel = 1; Bwrite = 1; step(); check(S_B, 16'hFFF0);
        ItypeSel = 1; Bwrite = 1; step(); check(S_B, 16'h00F0);

        // Reset overrides simultaneous strobes
        Reset_n = 0; Data_In = 16'h1234; IR_Write = 1; Awrite = 1; reg_write = 1; destAddr = 0;
        ALUcontrol = 2; iszero_write = 1; step();
        check(S_IR, 0); check(S_A, 0); check(S_B, 0); check(S_ZERO, 0); check(S_ACC, 0);
        Reset_n = 1;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge Clock);
        if (sb.size() > 0) begin
            miscompares += sb.size();
            $display("FAIL scoreboard: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
